div_unit: RTL and testbench

// - Multicycle signed 32-bit divider; responder to the control unit's DivOp start / div_end done handshake.
// - Produces quotient for LO and remainder for HI, feeding the HI_/LO_ registers beside mult.
// - Flags divide-by-zero so the control unit can take the exception path.
// - Operands come from the A_ and B_ registers.

---
 rtl/div_unit.sv | 146 ++++++++++++++
 tb/tb_div_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient to lo_out, remainder to hi_out.
// Divide-by-zero is reported immediately from IDLE without iterating.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_end,
    output logic             div_zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dvsr_reg;
    logic [WIDTH:0]   rem_reg;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             sign_r;

    logic             accept;
    logic             zero_hit;
    logic             last_iter;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;

    // Negating the most negative value yields 2^(WIDTH-1), which is still a
    // valid unsigned magnitude, so the overflow case needs no special path.
    assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

    assign rem_shift = {rem_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, dvsr_reg};
    assign rem_ge    = (rem_shift >= {1'b0, dvsr_reg});
    assign last_iter = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A zero-divisor start is suppressed while a pulse is already out, so a
    // held div_start cannot stretch div_end/div_zero across two cycles.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        zero_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (div_start) begin
                    if (divisor != '0) begin
                        accept     = 1'b1;
                        next_state = RUN;
                    end else if (!div_end) begin
                        zero_hit = 1'b1;
                    end
                end
            end
            RUN: begin
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg    <= '0;
            dvsr_reg <= '0;
            rem_reg  <= '0;
            count    <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            div_end  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
        end else begin
            div_end  <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        q_reg    <= dividend_mag;
                        dvsr_reg <= divisor_mag;
                        rem_reg  <= '0;
                        count    <= '0;
                        sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r   <= dividend[WIDTH-1];
                        busy     <= 1'b1;
                    end else if (zero_hit) begin
                        div_end  <= 1'b1;
                        div_zero <= 1'b1;
                    end
                end
                RUN: begin
                    if (rem_ge) begin
                        rem_reg <= rem_diff;
                        q_reg   <= {q_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_reg <= rem_shift;
                        q_reg   <= {q_reg[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                end
                DONE: begin
                    lo_out  <= sign_q ? -q_reg : q_reg;
                    hi_out  <= sign_r ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
                    div_end <= 1'b1;
                    busy    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: signs, overflow, divide-by-zero,
// mid-operation reset and ignored starts while busy.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        div_start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_end;
    logic        div_zero;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int busy_cycles;
    int pulses;
    int first_pulse;
    int cyc;
    logic [31:0] seen_lo;
    logic [31:0] seen_hi;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .div_start (div_start),
        .dividend  (dividend),
        .divisor   (divisor),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .div_end   (div_end),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Operands are scrambled right after the start edge to prove they were latched.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 output int latency, output int busy_cnt);
        dividend  = a;
        divisor   = b;
        div_start = 1'b1;
        waitCycle();
        div_start = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        latency   = 1;
        busy_cnt  = 0;
        while (!div_end && latency < 80) begin
            if (busy) busy_cnt++;
            waitCycle();
            latency++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        div_start = 1'b0;
        dividend  = '0;
        divisor   = '0;
        waitCycle();
        waitCycle();
        checkOutput("reset_hi", hi_out, 32'd0);
        checkOutput("reset_lo", lo_out, 32'd0);
        checkOutput("reset_end", {31'd0, div_end}, 32'd0);
        checkOutput("reset_zero", {31'd0, div_zero}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        waitCycle();

        $display("[TB] 7 / 2");
        applyStimulus(32'd7, 32'd2, lat, busy_cycles);
        checkOutput("p72_latency", lat, 34);
        checkOutput("p72_busy_cycles", busy_cycles, 33);
        checkOutput("p72_busy_at_end", {31'd0, busy}, 32'd0);
        checkOutput("p72_lo", lo_out, 32'd3);
        checkOutput("p72_hi", hi_out, 32'd1);
        checkOutput("p72_zero", {31'd0, div_zero}, 32'd0);
        waitCycle();
        checkOutput("p72_end_one_cycle", {31'd0, div_end}, 32'd0);
        checkOutput("p72_lo_hold", lo_out, 32'd3);

        $display("[TB] -7 / 2");
        applyStimulus(32'hFFFF_FFF9, 32'd2, lat, busy_cycles);
        checkOutput("n72_latency", lat, 34);
        checkOutput("n72_lo", lo_out, 32'hFFFF_FFFD);
        checkOutput("n72_hi", hi_out, 32'hFFFF_FFFF);
        waitCycle();

        $display("[TB] 7 / -2");
        applyStimulus(32'd7, 32'hFFFF_FFFE, lat, busy_cycles);
        checkOutput("p7n2_lo", lo_out, 32'hFFFF_FFFD);
        checkOutput("p7n2_hi", hi_out, 32'd1);
        waitCycle();

        $display("[TB] 0x80000000 / -1");
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, lat, busy_cycles);
        checkOutput("ovf_lo", lo_out, 32'h8000_0000);
        checkOutput("ovf_hi", hi_out, 32'd0);
        checkOutput("ovf_zero", {31'd0, div_zero}, 32'd0);
        waitCycle();

        $display("[TB] 7 / 2 then 5 / 0");
        applyStimulus(32'd7, 32'd2, lat, busy_cycles);
        waitCycle();
        dividend  = 32'd5;
        divisor   = 32'd0;
        div_start = 1'b1;
        waitCycle();
        div_start = 1'b0;
        checkOutput("dz_zero", {31'd0, div_zero}, 32'd1);
        checkOutput("dz_end", {31'd0, div_end}, 32'd1);
        checkOutput("dz_busy", {31'd0, busy}, 32'd0);
        checkOutput("dz_lo_kept", lo_out, 32'd3);
        checkOutput("dz_hi_kept", hi_out, 32'd1);
        waitCycle();
        checkOutput("dz_zero_drop", {31'd0, div_zero}, 32'd0);
        checkOutput("dz_end_drop", {31'd0, div_end}, 32'd0);
        checkOutput("dz_busy_after", {31'd0, busy}, 32'd0);

        $display("[TB] 100 / 7 aborted by reset");
        dividend  = 32'd100;
        divisor   = 32'd7;
        div_start = 1'b1;
        waitCycle();
        div_start = 1'b0;
        repeat (9) waitCycle();
        reset = 1'b1;
        waitCycle();
        reset = 1'b0;
        checkOutput("abort_hi", hi_out, 32'd0);
        checkOutput("abort_lo", lo_out, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            if (div_end) pulses++;
            waitCycle();
        end
        checkOutput("abort_no_end", pulses, 0);

        $display("[TB] 100 / 7 after reset");
        applyStimulus(32'd100, 32'd7, lat, busy_cycles);
        checkOutput("r100_latency", lat, 34);
        checkOutput("r100_lo", lo_out, 32'd14);
        checkOutput("r100_hi", hi_out, 32'd2);
        waitCycle();

        $display("[TB] 9 / 4 with start while busy");
        dividend  = 32'd9;
        divisor   = 32'd4;
        div_start = 1'b1;
        waitCycle();
        div_start = 1'b0;
        repeat (4) waitCycle();
        dividend  = 32'd1;
        divisor   = 32'd1;
        div_start = 1'b1;
        waitCycle();
        div_start = 1'b0;
        cyc         = 6;
        pulses      = 0;
        first_pulse = -1;
        seen_lo     = '0;
        seen_hi     = '0;
        while (cyc < 90) begin
            if (div_end) begin
                pulses++;
                if (pulses == 1) begin
                    first_pulse = cyc;
                    seen_lo     = lo_out;
                    seen_hi     = hi_out;
                end
            end
            waitCycle();
            cyc++;
        end
        checkOutput("busy_start_pulses", pulses, 1);
        checkOutput("busy_start_latency", first_pulse, 34);
        checkOutput("busy_start_lo", seen_lo, 32'd2);
        checkOutput("busy_start_hi", seen_hi, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
